// File: rtl/dcache_refill_unit.sv
// dcache_refill_unit: read-miss line refill for data_cache.
// Fetches one BLOCK_SIZE-bit line as a burst of 32-bit beats, assembles it,
// then presents it on the repair port for a single cycle.
// Build option: define DCACHE_REFILL_CWF_EN for critical-word-first bursts
// with an early critical-word strobe; undefined gives line-aligned bursts
// with the critical word returned together with the repair strobe.
module dcache_refill_unit #(
    parameter int unsigned BLOCK_SIZE = 128,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_req_i,
    input  logic [ADDR_WIDTH-1:0] miss_addr_i,
    output logic                  miss_ready_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i,
    output logic                  is_repair_o,
    output logic [BLOCK_SIZE-1:0] repair_data_o,
    output logic [ADDR_WIDTH-1:0] repair_addr_o,
    output logic                  crit_valid_o,
    output logic [31:0]           crit_data_o
);

    localparam int unsigned WORDS = BLOCK_SIZE / 32;
    localparam int unsigned IDXW  = $clog2(WORDS);
    localparam int unsigned OFFW  = $clog2(BLOCK_SIZE / 8);
    localparam int unsigned CNTW  = IDXW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_WIDTH-1:0] repair_addr_q, repair_addr_d;
    logic [BLOCK_SIZE-1:0] line_q, line_d;
    logic [BLOCK_SIZE-1:0] repair_data_q, repair_data_d;
    logic [IDXW-1:0]       crit_idx_q, crit_idx_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic                  crit_valid_q, crit_valid_d;
    logic [31:0]           crit_data_q, crit_data_d;

    logic [IDXW-1:0]       start_idx;
    logic [IDXW-1:0]       slot;
    logic                  beat;
    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] req_line_addr;
    logic [ADDR_WIDTH-1:0] req_burst_addr;

    // Byte-offset bits of the load address are not needed for a word refill.
    logic unused_addr_bits;
    assign unused_addr_bits = ^miss_addr_i[1:0];

    // Burst start word within the line: the critical word or word 0.
    always_comb begin
`ifdef DCACHE_REFILL_CWF_EN
        start_idx = crit_idx_q;
`else
        start_idx = '0;
`endif
    end

    // Address decode of the incoming miss.
    always_comb begin
        req_line_addr = {miss_addr_i[ADDR_WIDTH-1:OFFW], OFFW'(0)};
`ifdef DCACHE_REFILL_CWF_EN
        req_burst_addr = {miss_addr_i[ADDR_WIDTH-1:2], 2'b00};
`else
        req_burst_addr = req_line_addr;
`endif
    end

    assign slot      = start_idx + cnt_q[IDXW-1:0];
    assign beat      = (state_q == FILL) && mem_rvalid_i;
    assign last_beat = beat && (cnt_q == CNTW'(WORDS - 1));

    // Next-state and datapath updates.
    always_comb begin
        state_d       = state_q;
        line_addr_d   = line_addr_q;
        mem_addr_d    = mem_addr_q;
        repair_addr_d = repair_addr_q;
        line_d        = line_q;
        repair_data_d = repair_data_q;
        crit_idx_d    = crit_idx_q;
        cnt_d         = cnt_q;
        crit_valid_d  = 1'b0;
        crit_data_d   = crit_data_q;

        if (beat) begin
            line_d[{slot, 5'd0} +: 32] = mem_rdata_i;
        end

        case (state_q)
            IDLE: begin
                if (miss_req_i) begin
                    line_addr_d = req_line_addr;
                    mem_addr_d  = req_burst_addr;
                    crit_idx_d  = miss_addr_i[IDXW+1:2];
                    cnt_d       = '0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (beat) begin
                    cnt_d = cnt_q + CNTW'(1);
`ifdef DCACHE_REFILL_CWF_EN
                    if (cnt_q == '0) begin
                        crit_valid_d = 1'b1;
                        crit_data_d  = mem_rdata_i;
                    end
`endif
                end
                if (last_beat) begin
                    state_d       = DONE;
                    repair_data_d = line_d;
                    repair_addr_d = line_addr_q;
`ifndef DCACHE_REFILL_CWF_EN
                    crit_valid_d  = 1'b1;
                    crit_data_d   = line_d[{crit_idx_q, 5'd0} +: 32];
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_addr_q   <= '0;
            mem_addr_q    <= '0;
            repair_addr_q <= '0;
            line_q        <= '0;
            repair_data_q <= '0;
            crit_idx_q    <= '0;
            cnt_q         <= '0;
            crit_valid_q  <= 1'b0;
            crit_data_q   <= '0;
        end else begin
            line_addr_q   <= line_addr_d;
            mem_addr_q    <= mem_addr_d;
            repair_addr_q <= repair_addr_d;
            line_q        <= line_d;
            repair_data_q <= repair_data_d;
            crit_idx_q    <= crit_idx_d;
            cnt_q         <= cnt_d;
            crit_valid_q  <= crit_valid_d;
            crit_data_q   <= crit_data_d;
        end
    end

    assign miss_ready_o  = (state_q == IDLE);
    assign mem_req_o     = (state_q == REQ);
    assign is_repair_o   = (state_q == DONE);
    assign mem_addr_o    = mem_addr_q;
    assign repair_data_o = repair_data_q;
    assign repair_addr_o = repair_addr_q;
    assign crit_valid_o  = crit_valid_q;
    assign crit_data_o   = crit_data_q;

endmodule
